bridge_controller: RTL and testbench
====================================

# bridge_controller

Parametrised drawbridge controller: a single Moore FSM that sequences the complete raise/lower cycle of the bridge deck, covering road warning, deck-clear qualification, motor drive, limit-switch completion, obstacle reversal and timeout fault. It generalises the fixed six-sensor lowering logic to configurable deck and boat sensor counts, with timed qualification and supervision. It sits between the sensor/operator input synchronisers and the motor, alarm and traffic-light drivers.

## Interface
- N_DECK, 4: number of deck vehicle-presence sensors (≥1)
- N_BOAT, 2: number of boat-approach sensors (≥1)
- CLEAR_CYCLES, 16: consecutive deck-clear cycles required before raising (≥1)
- MOVE_TIMEOUT, 1024: maximum cycles allowed in RAISING/LOWERING before FAULT (≥2)
- Clock  in  1  system clock, all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset
- RaiseReq  in  1  operator raise request (level)
- LowerReq  in  1  operator lower request (level)
- CarSens  in  N_DECK  vehicle present on deck, one bit per sensor
- BoatSens  in  N_BOAT  boat approaching, one bit per sensor
- TopLimit  in  1  deck fully raised
- BottomLimit  in  1  deck fully lowered
- Obstacle  in  1  obstruction under descending deck
- MotorUp  out  1  drive motor upward
- MotorDown  out  1  drive motor downward
- AL  out  1  audible/visual alarm
- TFL  out  1  road traffic light: 1 = red (stop), 0 = green
- Fault  out  1  latched fault indicator
- State  out  3  current state encoding, for debug

## Operation
- All inputs are already synchronised to Clock upstream; no internal synchronisers.
- States: FLAT(0), WARN(1), RAISING(2), UP(3), LOWERING(4), FAULT(5); codes 6–7 are unreachable and go to FAULT.
- Outputs are decoded from the state register only (Moore):
  - FLAT: all outputs 0
  - WARN: TFL=1, AL=1
  - RAISING: MotorUp=1, TFL=1, AL=1
  - UP: TFL=1
  - LOWERING: MotorDown=1, TFL=1, AL=1
  - FAULT: TFL=1, AL=1, Fault=1; motors off
- MotorUp and MotorDown are never both 1.
- FLAT→WARN when RaiseReq | (|BoatSens).
- WARN:
  - clear counter increments on each cycle with ~|CarSens; any CarSens bit set clears it to 0
  - →RAISING on the cycle the counter equals CLEAR_CYCLES−1 with the deck still clear
  - request withdrawal does not abort WARN
- RAISING→UP on TopLimit.
- UP→LOWERING when LowerReq & ~(|BoatSens).
- LOWERING:
  - Obstacle → RAISING (reversal); Obstacle has priority over BottomLimit
  - else BottomLimit → FLAT
- Timeout: one move counter, cleared on every state entry, increments each cycle in RAISING/LOWERING.
  - If the counter equals MOVE_TIMEOUT−1 and the awaited limit is not asserted, the next edge goes to FAULT.
  - A limit asserted in that same cycle wins over the timeout.
- TopLimit & BottomLimit both asserted, from any state → FAULT (highest priority).
- FAULT is exited only by Reset.
- Counter widths: $clog2(CLEAR_CYCLES+1) and $clog2(MOVE_TIMEOUT+1); counters saturate, never wrap.

## Timing
- Reset asserted (low): state=FLAT, both counters=0, all outputs 0 immediately, without waiting for a clock edge. Motors stop mid-motion.
- Reset release: first transition possible on the first rising edge with Reset high.
- Every transition takes effect on the edge after its condition is sampled; outputs change on that same edge (1-cycle input→output latency).
- Minimum WARN dwell is CLEAR_CYCLES cycles.
- Maximum RAISING/LOWERING dwell is MOVE_TIMEOUT cycles.
- An Obstacle reversal restarts the move counter from 0 on entry to RAISING.

## Structure
- Package bridge_pkg holds:
  - state enum and its encodings
  - output-decode constants
  - default parameter values
- Sub-module bridge_cycle_counter: parametrised width, with clear, enable and terminal-count flag. It is instantiated twice, once as the clear counter and once as the move counter.
- FSM and output decode live in bridge_controller.

## Test plan
Parameters: CLEAR_CYCLES=4, MOVE_TIMEOUT=10.

- Full cycle: RaiseReq pulse, deck clear, TopLimit after 5 RAISING cycles, then LowerReq, BottomLimit after 5 cycles. Required sequence: FLAT→WARN (4 cycles)→RAISING→UP→LOWERING→FLAT; TFL returns to 0.
- Car in WARN: CarSens=4'b0010 on WARN cycle 3, clear afterwards. WARN lasts 3+4=7 cycles before RAISING.
- Timeout: enter RAISING, never assert TopLimit. FAULT after exactly 10 RAISING cycles with Fault=1 and motors 0; FAULT persists with RaiseReq/LowerReq toggling until Reset.
- Obstacle: Obstacle=1 in LOWERING cycle 3 (together with BottomLimit). Next state is RAISING with MotorUp=1 and move counter restarted; TopLimit → UP.
- Boat interlock: in UP with BoatSens=2'b01 and LowerReq=1, state stays UP; clearing BoatSens gives LOWERING one cycle later.
- Async reset and limit conflict: Reset low mid-RAISING clears all outputs with no clock edge. Separately, TopLimit=BottomLimit=1 in FLAT → FAULT on the next edge.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the drawbridge controller: state codes,
// per-state output patterns and default parameter values.
package bridge_pkg;

  localparam int DefNDeck        = 4;
  localparam int DefNBoat        = 2;
  localparam int DefClearCycles  = 16;
  localparam int DefMoveTimeout  = 1024;

  typedef enum logic [2:0] {
    StFlat     = 3'd0,
    StWarn     = 3'd1,
    StRaising  = 3'd2,
    StUp       = 3'd3,
    StLowering = 3'd4,
    StFault    = 3'd5
  } state_e;

  typedef struct packed {
    logic motorUp;
    logic motorDown;
    logic al;
    logic tfl;
    logic fault;
  } drive_t;

  // Output patterns, bit order {motorUp, motorDown, al, tfl, fault}
  localparam logic [4:0] DriveFlat     = 5'b00000;
  localparam logic [4:0] DriveWarn     = 5'b00110;
  localparam logic [4:0] DriveRaising  = 5'b10110;
  localparam logic [4:0] DriveUp       = 5'b00010;
  localparam logic [4:0] DriveLowering = 5'b01110;
  localparam logic [4:0] DriveFault    = 5'b00111;

  function automatic drive_t decodeDrive(input state_e s);
    drive_t d;
    case (s)
      StFlat:     d = drive_t'(DriveFlat);
      StWarn:     d = drive_t'(DriveWarn);
      StRaising:  d = drive_t'(DriveRaising);
      StUp:       d = drive_t'(DriveUp);
      StLowering: d = drive_t'(DriveLowering);
      default:    d = drive_t'(DriveFault);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bridge_cycle_counter.sv
// Saturating cycle counter with synchronous clear, enable and a flag
// that is high while the count equals the configured terminal value.
module bridge_cycle_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam logic [WIDTH-1:0] MaxCount  = '1;
  localparam logic [WIDTH-1:0] TermValue = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count_q, count_d;

  // Clear wins over enable; the count holds at all-ones instead of wrapping
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != MaxCount)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, forced to zero while reset is held low
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == TermValue);

endmodule

// File: rtl/bridge_controller.sv
// Drawbridge sequencing FSM: road warning, deck-clear qualification,
// motor drive, limit completion, obstacle reversal and move timeout.
module bridge_controller
  import bridge_pkg::*;
#(
  parameter int N_DECK       = DefNDeck,
  parameter int N_BOAT       = DefNBoat,
  parameter int CLEAR_CYCLES = DefClearCycles,
  parameter int MOVE_TIMEOUT = DefMoveTimeout
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RaiseReq,
  input  logic              LowerReq,
  input  logic [N_DECK-1:0] CarSens,
  input  logic [N_BOAT-1:0] BoatSens,
  input  logic              TopLimit,
  input  logic              BottomLimit,
  input  logic              Obstacle,
  output logic              MotorUp,
  output logic              MotorDown,
  output logic              AL,
  output logic              TFL,
  output logic              Fault,
  output logic [2:0]        State
);

  localparam int ClearW = $clog2(CLEAR_CYCLES + 1);
  localparam int MoveW  = $clog2(MOVE_TIMEOUT + 1);

  state_e state_q, state_d;
  drive_t drive;
  logic   deckClear;
  logic   boatNear;
  logic   moving;
  logic   clearDone;
  logic   moveExpired;

  assign deckClear = ~|CarSens;
  assign boatNear  = |BoatSens;
  assign moving    = (state_q == StRaising) || (state_q == StLowering);

  // Counts consecutive clear-deck cycles while warning; a car restarts it
  bridge_cycle_counter #(
    .WIDTH    (ClearW),
    .TERMINAL (CLEAR_CYCLES - 1)
  ) u_clearCounter (
    .Clock      (Clock),
    .Reset      (Reset),
    .clear_i    ((state_q != StWarn) || !deckClear),
    .enable_i   (state_q == StWarn),
    .terminal_o (clearDone)
  );

  // Counts cycles spent moving; restarts on every state change
  bridge_cycle_counter #(
    .WIDTH    (MoveW),
    .TERMINAL (MOVE_TIMEOUT - 1)
  ) u_moveCounter (
    .Clock      (Clock),
    .Reset      (Reset),
    .clear_i    (state_d != state_q),
    .enable_i   (moving),
    .terminal_o (moveExpired)
  );

  // State register; reset drops the deck sequence straight back to FLAT
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StFlat;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a limit conflict overrides everything else
  always_comb begin
    state_d = state_q;
    if (TopLimit && BottomLimit) begin
      state_d = StFault;
    end else begin
      case (state_q)
        StFlat:     if (RaiseReq || boatNear) state_d = StWarn;
        StWarn:     if (deckClear && clearDone) state_d = StRaising;
        StRaising: begin
          if (TopLimit)         state_d = StUp;
          else if (moveExpired) state_d = StFault;
        end
        StUp:       if (LowerReq && !boatNear) state_d = StLowering;
        StLowering: begin
          if (Obstacle)         state_d = StRaising;
          else if (BottomLimit) state_d = StFlat;
          else if (moveExpired) state_d = StFault;
        end
        StFault:    state_d = StFault;
        default:    state_d = StFault;
      endcase
    end
  end

  assign drive     = decodeDrive(state_q);
  assign MotorUp   = drive.motorUp;
  assign MotorDown = drive.motorDown;
  assign AL        = drive.al;
  assign TFL       = drive.tfl;
  assign Fault     = drive.fault;
  assign State     = state_q;

endmodule

// File: tb/tb_bridge_controller.sv
// Bench for bridge_controller with CLEAR_CYCLES=4 and MOVE_TIMEOUT=10.
module tb_bridge_controller;

  localparam int ClearCycles = 4;
  localparam int MoveTimeout = 10;

  logic       Clock       = 1'b0;
  logic       Reset       = 1'b0;
  logic       RaiseReq    = 1'b0;
  logic       LowerReq    = 1'b0;
  logic [3:0] CarSens     = 4'b0000;
  logic [1:0] BoatSens    = 2'b00;
  logic       TopLimit    = 1'b0;
  logic       BottomLimit = 1'b0;
  logic       Obstacle    = 1'b0;
  logic       MotorUp, MotorDown, AL, TFL, Fault;
  logic [2:0] State;

  int checkCount = 0;
  int failCount  = 0;
  int n;

  always #5 Clock = ~Clock;

  bridge_controller #(
    .N_DECK       (4),
    .N_BOAT       (2),
    .CLEAR_CYCLES (ClearCycles),
    .MOVE_TIMEOUT (MoveTimeout)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .RaiseReq    (RaiseReq),
    .LowerReq    (LowerReq),
    .CarSens     (CarSens),
    .BoatSens    (BoatSens),
    .TopLimit    (TopLimit),
    .BottomLimit (BottomLimit),
    .Obstacle    (Obstacle),
    .MotorUp     (MotorUp),
    .MotorDown   (MotorDown),
    .AL          (AL),
    .TFL         (TFL),
    .Fault       (Fault),
    .State       (State)
  );

  // Reference behaviour: state as a number, WARN tracked as a run of clear
  // cycles seen so far and motion tracked as cycles spent in the move
  int mState  = 0;
  int warnRun = 0;
  int moveRun = 0;
  int nsV, wrV, mrV;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mState  <= 0;
      warnRun <= 0;
      moveRun <= 0;
    end else begin
      nsV = mState;
      wrV = 0;
      mrV = moveRun + 1;
      if (TopLimit && BottomLimit) begin
        nsV = 5;
      end else begin
        case (mState)
          0: if (RaiseReq || BoatSens != 2'b00) nsV = 1;
          1: begin
            wrV = (CarSens != 4'b0000) ? 0 : warnRun + 1;
            if (wrV >= ClearCycles) nsV = 2;
          end
          2: if (TopLimit) nsV = 3; else if (mrV >= MoveTimeout) nsV = 5;
          3: if (LowerReq && BoatSens == 2'b00) nsV = 4;
          4: begin
            if (Obstacle) nsV = 2;
            else if (BottomLimit) nsV = 0;
            else if (mrV >= MoveTimeout) nsV = 5;
          end
          default: nsV = 5;
        endcase
      end
      warnRun <= (nsV == 1) ? wrV : 0;
      moveRun <= (nsV == mState && (nsV == 2 || nsV == 4)) ? mrV : 0;
      mState  <= nsV;
    end
  end

  // Expected {State, MotorUp, MotorDown, AL, TFL, Fault} for a state number
  function automatic int expectVec(input int s);
    int drive;
    case (s)
      0:       drive = 'b00000;
      1:       drive = 'b00110;
      2:       drive = 'b10110;
      3:       drive = 'b00010;
      4:       drive = 'b01110;
      default: drive = 'b00111;
    endcase
    return (s << 5) | drive;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic countDwell(input logic [2:0] s, output int cycles);
    cycles = 0;
    while (State == s && cycles < 200) begin
      cycles++;
      @(posedge Clock);
      #1;
    end
    if (cycles >= 200) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL dwellBound: state %0d still held after %0d cycles", s, cycles);
    end
  endtask

  function automatic int outVec();
    return int'({State, MotorUp, MotorDown, AL, TFL, Fault});
  endfunction

  // Every cycle, outputs must match the reference state
  always @(negedge Clock) begin
    checkOutput("cycle", outVec(), expectVec(mState));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    checkOutput("resetOutputs", outVec(), 0);
    applyStimulus(1);
    Reset = 1'b1;
    applyStimulus(1);

    // Full raise/lower cycle
    RaiseReq = 1'b1; applyStimulus(1); RaiseReq = 1'b0;
    countDwell(3'd1, n);
    checkOutput("warnDwell", n, 4);
    checkOutput("raisingEntry", outVec(), 'b010_10110);
    applyStimulus(4);
    TopLimit = 1'b1; applyStimulus(1); TopLimit = 1'b0;
    checkOutput("upState", int'(State), 3);
    LowerReq = 1'b1; applyStimulus(1); LowerReq = 1'b0;
    checkOutput("loweringEntry", outVec(), 'b100_01110);
    applyStimulus(4);
    BottomLimit = 1'b1; applyStimulus(1); BottomLimit = 1'b0;
    checkOutput("flatAgain", outVec(), 0);

    // Car appears on WARN cycle 3
    BoatSens = 2'b10; applyStimulus(1); BoatSens = 2'b00;
    applyStimulus(2);
    CarSens = 4'b0010; applyStimulus(1); CarSens = 4'b0000;
    countDwell(3'd1, n);
    checkOutput("warnDwellCar", n + 3, 7);
    TopLimit = 1'b1; applyStimulus(1); TopLimit = 1'b0;
    LowerReq = 1'b1; applyStimulus(1); LowerReq = 1'b0;
    BottomLimit = 1'b1; applyStimulus(1); BottomLimit = 1'b0;
    checkOutput("flatAfterCar", int'(State), 0);

    // Raising timeout into a latched fault
    RaiseReq = 1'b1; applyStimulus(1); RaiseReq = 1'b0;
    countDwell(3'd1, n);
    countDwell(3'd2, n);
    checkOutput("raiseTimeoutDwell", n, 10);
    checkOutput("faultOutputs", outVec(), 'b101_00111);
    for (int i = 0; i < 6; i++) begin
      RaiseReq = i[0];
      LowerReq = ~i[0];
      applyStimulus(1);
    end
    RaiseReq = 1'b0; LowerReq = 1'b0;
    checkOutput("faultHeld", int'(State), 5);
    Reset = 1'b0; #1;
    checkOutput("faultCleared", outVec(), 0);
    applyStimulus(1); Reset = 1'b1;

    // Obstacle reversal with BottomLimit in the same cycle
    RaiseReq = 1'b1; applyStimulus(1); RaiseReq = 1'b0;
    countDwell(3'd1, n);
    TopLimit = 1'b1; applyStimulus(1); TopLimit = 1'b0;
    LowerReq = 1'b1; applyStimulus(1); LowerReq = 1'b0;
    applyStimulus(2);
    Obstacle = 1'b1; BottomLimit = 1'b1; applyStimulus(1);
    Obstacle = 1'b0; BottomLimit = 1'b0;
    checkOutput("reversal", outVec(), 'b010_10110);
    applyStimulus(9);
    checkOutput("reversalRestart", int'(State), 2);
    TopLimit = 1'b1; applyStimulus(1); TopLimit = 1'b0;
    checkOutput("limitBeatsTimeout", int'(State), 3);

    // Boat holds the deck up
    BoatSens = 2'b01; LowerReq = 1'b1; applyStimulus(3);
    checkOutput("boatInterlock", int'(State), 3);
    BoatSens = 2'b00; applyStimulus(1);
    checkOutput("boatGone", int'(State), 4);
    LowerReq = 1'b0;
    BottomLimit = 1'b1; applyStimulus(1); BottomLimit = 1'b0;

    // Asynchronous reset in the middle of a raise
    RaiseReq = 1'b1; applyStimulus(1); RaiseReq = 1'b0;
    countDwell(3'd1, n);
    applyStimulus(2);
    checkOutput("midRaise", int'(MotorUp), 1);
    #2; Reset = 1'b0; #1;
    checkOutput("asyncReset", outVec(), 0);
    applyStimulus(1); Reset = 1'b1;

    // Both limits at once from FLAT
    TopLimit = 1'b1; BottomLimit = 1'b1; applyStimulus(1);
    TopLimit = 1'b0; BottomLimit = 1'b0;
    checkOutput("limitConflict", outVec(), 'b101_00111);
    Reset = 1'b0; applyStimulus(1); Reset = 1'b1;
    applyStimulus(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
